// File: rtl/s420_stim_seq_if.sv
// -----------------------------------------------------------------------------
// s420_stim_seq_if
//   Handshake / bus bundle between the stimulus sequencer and its host.
//   master : host side (drives mask shift, run request, pause/abort)
//   slave  : sequencer side (drives P_0, compare mask, BUSY, DONE)
// Signals
//   SI     serial mask data in          SE     shift enable (IDLE only)
//   START  run request (IDLE only)      LEN    run length, sampled with START
//   PAUSE  hold the run                 ABORT  terminate run without DONE
//   P_0    count enable to counter      C      compare mask, bit i is C_i
//   BUSY   run or hold in progress      DONE   one-cycle completion pulse
// -----------------------------------------------------------------------------
interface s420_stim_seq_if #(
   parameter int LEN_W  = 16,
   parameter int MASK_W = 17
);
   logic              SI;
   logic              SE;
   logic              START;
   logic [LEN_W-1:0]  LEN;
   logic              PAUSE;
   logic              ABORT;
   logic              P_0;
   logic [MASK_W-1:0] C;
   logic              BUSY;
   logic              DONE;

   modport master (
      output SI, SE, START, LEN, PAUSE, ABORT,
      input  P_0, C, BUSY, DONE
   );

   modport slave (
      input  SI, SE, START, LEN, PAUSE, ABORT,
      output P_0, C, BUSY, DONE
   );
endinterface

// File: rtl/s420_stim_seq.sv
// -----------------------------------------------------------------------------
// s420_stim_seq
//   Upstream stimulus sequencer for the 16-bit counter/comparator stage.
//   Loads a compare mask serially while idle, then runs the counter stage by
//   holding P_0 high for exactly LEN cycles, with pause and abort support.
// Ports
//   CK   clock, all state changes on the rising edge
//   RN   asynchronous active-low reset (clears state, mask and count)
//   bus  s420_stim_seq_if.slave: SI/SE/START/LEN/PAUSE/ABORT in,
//        P_0/C/BUSY/DONE out (all outputs decoded from registers)
// -----------------------------------------------------------------------------
module s420_stim_seq #(
   parameter int LEN_W  = 16,
   parameter int MASK_W = 17
) (
   input  logic                 CK,
   input  logic                 RN,
   s420_stim_seq_if.slave       bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [MASK_W-1:0] mask_q,  mask_d;
   logic [LEN_W-1:0]  cnt_q,   cnt_d;

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         state_q <= ST_IDLE;
         mask_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            // START takes priority; a shift requested in the same cycle is dropped.
            if (bus.START) begin
               if (|bus.LEN) begin
                  cnt_d   = bus.LEN;
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_DONE;
               end
            end else if (bus.SE) begin
               mask_d = {mask_q[MASK_W-2:0], bus.SI};
            end
         end
         ST_RUN: begin
            // Each RUN cycle consumes one count; the last one ignores PAUSE so
            // the total number of P_0-high cycles is always exactly LEN.
            if (bus.ABORT) begin
               state_d = ST_IDLE;
            end else if (cnt_q == LEN_W'(1)) begin
               state_d = ST_DONE;
            end else begin
               cnt_d   = cnt_q - LEN_W'(1);
               state_d = bus.PAUSE ? ST_HOLD : ST_RUN;
            end
         end
         ST_HOLD: begin
            if (bus.ABORT) begin
               state_d = ST_IDLE;
            end else if (!bus.PAUSE) begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.P_0  = (state_q == ST_RUN);
   assign bus.BUSY = (state_q == ST_RUN) || (state_q == ST_HOLD);
   assign bus.DONE = (state_q == ST_DONE);
   assign bus.C    = mask_q;

endmodule

// File: tb/tb_s420_stim_seq.sv
module tb_s420_stim_seq;
   localparam int LEN_W  = 16;
   localparam int MASK_W = 17;

   logic CK = 1'b0;
   logic RN = 1'b0;
   always #5 CK = ~CK;

   s420_stim_seq_if #(.LEN_W(LEN_W), .MASK_W(MASK_W)) bus ();

   s420_stim_seq #(.LEN_W(LEN_W), .MASK_W(MASK_W)) dut (
      .CK  (CK),
      .RN  (RN),
      .bus (bus)
   );

   typedef struct {
      logic              p0;
      logic              busy;
      logic              done;
      logic [MASK_W-1:0] c;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   p0_cnt;

   // Stand-in for the attached counter stage: one increment per enabled cycle.
   always @(posedge CK or negedge RN) begin
      if (!RN) p0_cnt <= 0;
      else if (bus.P_0) p0_cnt <= p0_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic p0, input logic busy, input logic done,
                       input logic [MASK_W-1:0] c);
      exp_t e;
      e.p0 = p0; e.busy = busy; e.done = done; e.c = c;
      sb_q.push_back(e);
   endtask

   // Drive one cycle of stimulus, let the edge happen, then check the
   // oldest expected output set against what the DUT now presents.
   task automatic cyc(input string tag, input logic start, input logic [LEN_W-1:0] len,
                      input logic se, input logic si, input logic pause, input logic abort);
      exp_t e;
      bus.START = start; bus.LEN = len; bus.SE = se; bus.SI = si;
      bus.PAUSE = pause; bus.ABORT = abort;
      @(posedge CK);
      #1;
      if (sb_q.size() == 0) begin
         chk({tag, ".sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         chk({tag, ".P_0"},  {31'd0, bus.P_0},  {31'd0, e.p0});
         chk({tag, ".BUSY"}, {31'd0, bus.BUSY}, {31'd0, e.busy});
         chk({tag, ".DONE"}, {31'd0, bus.DONE}, {31'd0, e.done});
         chk({tag, ".C"},    {15'd0, bus.C},    {15'd0, e.c});
      end
   endtask

   initial begin
      logic [MASK_W-1:0] exp_mask;
      logic [MASK_W-1:0] pat;
      logic              si;
      int                base;

      bus.SI = 0; bus.SE = 0; bus.START = 0; bus.LEN = '0; bus.PAUSE = 0; bus.ABORT = 0;

      // Reset state
      #12;
      chk("rst.P_0",  {31'd0, bus.P_0},  32'd0);
      chk("rst.BUSY", {31'd0, bus.BUSY}, 32'd0);
      chk("rst.DONE", {31'd0, bus.DONE}, 32'd0);
      chk("rst.C",    {15'd0, bus.C},    32'd0);
      @(negedge CK); RN = 1'b1;
      @(posedge CK); #1;

      // Mask load: 1 then sixteen 0s; the first bit ends up in C_16
      exp_mask = '0;
      for (int i = 0; i < 17; i++) begin
         si = (i == 0);
         exp_mask = {exp_mask[MASK_W-2:0], si};
         push(1'b0, 1'b0, 1'b0, exp_mask);
         cyc("load", 1'b0, '0, 1'b1, si, 1'b0, 1'b0);
      end
      chk("load.C16only", {15'd0, bus.C}, 32'h0001_0000);
      push(1'b0, 1'b0, 1'b0, '0);
      cyc("load18", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("load18.zero", {15'd0, bus.C}, 32'd0);

      // Load a working pattern MSB first
      pat = 17'h12C35;
      exp_mask = '0;
      for (int i = MASK_W - 1; i >= 0; i--) begin
         exp_mask = {exp_mask[MASK_W-2:0], pat[i]};
         push(1'b0, 1'b0, 1'b0, exp_mask);
         cyc("pat", 1'b0, '0, 1'b1, pat[i], 1'b0, 1'b0);
      end
      chk("pat.C", {15'd0, bus.C}, {15'd0, pat});

      // Run LEN=5; SE held high during the run must not disturb the mask
      base = p0_cnt;
      for (int i = 0; i < 5; i++) push(1'b1, 1'b1, 1'b0, pat);
      push(1'b0, 1'b0, 1'b1, pat);
      push(1'b0, 1'b0, 1'b0, pat);
      cyc("run5", 1'b1, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) cyc("run5", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("run5.incs", p0_cnt - base, 32'd5);

      // LEN=0: DONE next cycle, no P_0 and no BUSY
      base = p0_cnt;
      push(1'b0, 1'b0, 1'b1, pat);
      push(1'b0, 1'b0, 1'b0, pat);
      cyc("len0", 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("len0", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("len0.incs", p0_cnt - base, 32'd0);

      // Pause: LEN=4, PAUSE high for 3 cycles after the 2nd P_0 cycle
      base = p0_cnt;
      push(1'b1, 1'b1, 1'b0, pat);
      push(1'b1, 1'b1, 1'b0, pat);
      for (int i = 0; i < 3; i++) push(1'b0, 1'b1, 1'b0, pat);
      push(1'b1, 1'b1, 1'b0, pat);
      push(1'b1, 1'b1, 1'b0, pat);
      push(1'b0, 1'b0, 1'b1, pat);
      push(1'b0, 1'b0, 1'b0, pat);
      cyc("pause", 1'b1, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("pause", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc("pause", 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cyc("pause", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("pause.incs", p0_cnt - base, 32'd4);

      // Abort in the 3rd cycle of an LEN=10 run: no DONE afterwards
      for (int i = 0; i < 3; i++) push(1'b1, 1'b1, 1'b0, pat);
      for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b0, pat);
      cyc("abort", 1'b1, 16'd10, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("abort", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("abort", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("abort", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc("abort", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("abort", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

      // START and SE together: run starts, shift discarded
      push(1'b1, 1'b1, 1'b0, pat);
      push(1'b0, 1'b0, 1'b1, pat);
      push(1'b0, 1'b0, 1'b0, pat);
      cyc("prio", 1'b1, 16'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("prio", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("prio", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset mid-run with LEN=100: outputs drop without waiting for an edge
      for (int i = 0; i < 3; i++) push(1'b1, 1'b1, 1'b0, pat);
      cyc("mrun", 1'b1, 16'd100, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("mrun", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("mrun", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge CK);
      RN = 1'b0;
      #1;
      chk("mrst.P_0",  {31'd0, bus.P_0},  32'd0);
      chk("mrst.BUSY", {31'd0, bus.BUSY}, 32'd0);
      chk("mrst.DONE", {31'd0, bus.DONE}, 32'd0);
      @(negedge CK);
      RN = 1'b1;
      push(1'b0, 1'b0, 1'b0, '0);
      push(1'b0, 1'b0, 1'b0, '0);
      cyc("postrst", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("postrst", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("postrst.sb_drained", sb_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
